// File: rtl/noc_pkg.sv
// Shared NoC definitions: header tag, field offsets and the receive FSM state type.
package noc_pkg;

  localparam int unsigned NOC_DATAW   = 512;
  localparam int unsigned NOC_USERW   = 75;
  localparam int unsigned NOC_HDR_OFS = NOC_DATAW;

  // The dispatcher stamps every packet with this tag in the header field
  localparam logic [NOC_USERW-1:0] NOC_EXP_TAG = NOC_USERW'(2'h2) << 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PKT,
    S_DROP
  } rx_state_t;

endpackage

// File: rtl/axis_collector_fifo.sv
// Common first-word-fall-through FIFO: head entry is visible on odata whenever empty=0.
module axis_collector_fifo #(
  parameter int unsigned WIDTH = 513,
  parameter int unsigned DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] idata,
  output logic [WIDTH-1:0] odata,
  output logic             empty,
  output logic             full,
  output logic             almost_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      level;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] mem [DEPTH];

  assign level       = wr_ptr - rd_ptr;
  assign empty       = (level == '0);
  assign full        = (level == (AW+1)'(DEPTH));
  assign almost_full = (level >= (AW+1)'(DEPTH - 1));
  assign do_push     = push & ~full;
  assign do_pop      = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= idata;
  end

  assign odata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/axis_collector.sv
// NoC receive collector: checks packet header/destination, strips the header,
// buffers payload beats for a local FWFT reader and counts delivered/dropped packets.
module axis_collector
  import noc_pkg::*;
#(
  parameter int unsigned       DATAW     = 512,
  parameter int unsigned       BYTEW     = 8,
  parameter int unsigned       IDW       = 32,
  parameter int unsigned       DESTW     = 7,
  parameter int unsigned       USERW     = 75,
  parameter int unsigned       DATAUSERW = DATAW + USERW,
  parameter logic [DESTW-1:0]  MYNODE    = '0,
  parameter logic [USERW-1:0]  EXP_TAG   = USERW'(NOC_EXP_TAG),
  parameter int unsigned       DEPTH     = 512,
  parameter int unsigned       CNTW      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 axis_rx_tvalid,
  input  logic [DATAUSERW-1:0] axis_rx_tdata,
  input  logic [BYTEW-1:0]     axis_rx_tstrb,
  input  logic [BYTEW-1:0]     axis_rx_tkeep,
  input  logic [IDW-1:0]       axis_rx_tid,
  input  logic [DESTW-1:0]     axis_rx_tdest,
  input  logic [USERW-1:0]     axis_rx_tuser,
  input  logic                 axis_rx_tlast,
  output logic                 axis_rx_tready,
  output logic [DATAW-1:0]     data_fifo_rdata,
  output logic                 data_fifo_rlast,
  output logic                 data_fifo_valid,
  input  logic                 data_fifo_ren,
  output logic [CNTW-1:0]      pkt_count,
  output logic [CNTW-1:0]      drop_count
);

  rx_state_t state;
  rx_state_t state_nxt;

  logic accept;
  logic hdr_ok;
  logic push;
  logic pkt_inc;
  logic drop_inc;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_almost_full;

  // Ready is a function of state and occupancy only, never of tvalid or ren
  assign axis_rx_tready = ~rst & ((state == S_DROP) | ~fifo_full);
  assign accept         = axis_rx_tvalid & axis_rx_tready;
  assign hdr_ok         = (axis_rx_tdata[DATAUSERW-1 -: USERW] == EXP_TAG) &&
                          (axis_rx_tdest == MYNODE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    if (accept) begin
      case (state)
        S_IDLE: begin
          if (hdr_ok) begin
            push      = 1'b1;
            pkt_inc   = axis_rx_tlast;
            state_nxt = axis_rx_tlast ? S_IDLE : S_PKT;
          end else begin
            drop_inc  = axis_rx_tlast;
            state_nxt = axis_rx_tlast ? S_IDLE : S_DROP;
          end
        end
        S_PKT: begin
          push    = 1'b1;
          pkt_inc = axis_rx_tlast;
          if (axis_rx_tlast) state_nxt = S_IDLE;
        end
        S_DROP: begin
          drop_inc = axis_rx_tlast;
          if (axis_rx_tlast) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Saturating packet counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (pkt_inc && (pkt_count != '1))   pkt_count  <= pkt_count + CNTW'(1);
      if (drop_inc && (drop_count != '1)) drop_count <= drop_count + CNTW'(1);
    end
  end

  axis_collector_fifo #(
    .WIDTH (DATAW + 1),
    .DEPTH (DEPTH)
  ) rx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (data_fifo_ren),
    .idata       ({axis_rx_tlast, axis_rx_tdata[DATAW-1:0]}),
    .odata       ({data_fifo_rlast, data_fifo_rdata}),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .almost_full (fifo_almost_full)
  );

  assign data_fifo_valid = ~fifo_empty;

  logic unused_ok;
  assign unused_ok = &{1'b0, axis_rx_tstrb, axis_rx_tkeep, axis_rx_tid,
                       axis_rx_tuser, fifo_almost_full};

endmodule

// File: tb/tb_axis_collector.sv
// Self-checking bench for axis_collector: directed scenarios plus a randomized
// packet stream scored against a packet-level reference model.
module tb_axis_collector;

  localparam int unsigned DATAW     = 512;
  localparam int unsigned BYTEW     = 8;
  localparam int unsigned IDW       = 32;
  localparam int unsigned DESTW     = 7;
  localparam int unsigned USERW     = 75;
  localparam int unsigned DATAUSERW = DATAW + USERW;
  localparam int unsigned DEPTH     = 512;
  localparam int unsigned CNTW      = 4;
  localparam int          SAT       = 15;
  localparam int          N4        = DEPTH + 4;

  localparam logic [USERW-1:0] GOOD_HDR = USERW'(12'h400);
  localparam logic [USERW-1:0] BAD_HDR  = USERW'(12'h200);

  typedef logic [DATAW:0] entry_t;

  logic                 clk;
  logic                 rst;
  logic                 tvalid;
  logic [DATAUSERW-1:0] tdata;
  logic [BYTEW-1:0]     tstrb;
  logic [BYTEW-1:0]     tkeep;
  logic [IDW-1:0]       tid;
  logic [DESTW-1:0]     tdest;
  logic [USERW-1:0]     tuser;
  logic                 tlast;
  logic                 axis_rx_tready;
  logic [DATAW-1:0]     data_fifo_rdata;
  logic                 data_fifo_rlast;
  logic                 data_fifo_valid;
  logic                 ren;
  logic [CNTW-1:0]      pkt_count;
  logic [CNTW-1:0]      drop_count;

  axis_collector #(
    .DATAW (DATAW), .BYTEW (BYTEW), .IDW (IDW), .DESTW (DESTW), .USERW (USERW),
    .DEPTH (DEPTH), .CNTW (CNTW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .axis_rx_tvalid  (tvalid),
    .axis_rx_tdata   (tdata),
    .axis_rx_tstrb   (tstrb),
    .axis_rx_tkeep   (tkeep),
    .axis_rx_tid     (tid),
    .axis_rx_tdest   (tdest),
    .axis_rx_tuser   (tuser),
    .axis_rx_tlast   (tlast),
    .axis_rx_tready  (axis_rx_tready),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_rlast (data_fifo_rlast),
    .data_fifo_valid (data_fifo_valid),
    .data_fifo_ren   (ren),
    .pkt_count       (pkt_count),
    .drop_count      (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compares = 0;
  int fails    = 0;

  // Reference model: buffered beats, delivered stream, observed stream, packet counters
  entry_t mfifo[$];
  entry_t exp_out[$];
  entry_t got_out[$];
  int     m_pkt;
  int     m_drop;
  bit     m_in_pkt;
  bit     m_good;
  bit     last_acc;
  bit     rand_ren;

  logic [DATAW-1:0] pl4 [N4];

  function automatic logic [DATAW-1:0] rand_pl();
    logic [DATAW-1:0] r;
    for (int i = 0; i < int'(DATAW / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input logic [DATAW-1:0] pl, input logic [USERW-1:0] hdr,
                       input logic [DESTW-1:0] dest, input logic last);
    tdata = {hdr, pl};
    tdest = dest;
    tlast = last;
  endtask

  // One clock: observe at the falling edge, update the model, return just after the rising edge
  task automatic step();
    if (rand_ren) ren = 1'($urandom_range(0, 1));
    @(negedge clk);
    last_acc = 1'b0;
    if (rst) begin
      mfifo.delete();
      exp_out.delete();
      got_out.delete();
      m_in_pkt = 1'b0;
      m_pkt    = 0;
      m_drop   = 0;
    end else begin
      if (ren && data_fifo_valid) got_out.push_back({data_fifo_rlast, data_fifo_rdata});
      if (ren && mfifo.size() > 0) exp_out.push_back(mfifo.pop_front());
      if (tvalid && axis_rx_tready) begin
        last_acc = 1'b1;
        if (!m_in_pkt) m_good = (tdata[DATAUSERW-1:DATAW] == GOOD_HDR) && (tdest == '0);
        if (m_good) mfifo.push_back({tlast, tdata[DATAW-1:0]});
        if (tlast) begin
          m_in_pkt = 1'b0;
          if (m_good) begin if (m_pkt < SAT) m_pkt++; end
          else begin if (m_drop < SAT) m_drop++; end
        end else begin
          m_in_pkt = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_beat(input logic [DATAW-1:0] pl, input logic [USERW-1:0] hdr,
                           input logic [DESTW-1:0] dest, input logic last);
    int n = 0;
    drive(pl, hdr, dest, last);
    tvalid = 1'b1;
    do begin
      step();
      n++;
    end while (!last_acc && n < 3000);
    if (!last_acc) begin
      compares++; fails++;
      $display("FAIL send_beat_timeout: beat not accepted after %0d cycles", n);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; tvalid = 1'b0; ren = 1'b0; rand_ren = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ren = 1'b0;
    drive(DATAW'(7), GOOD_HDR, '0, 1'b1);
    tvalid = 1'b1;
    step();
    compares += 5;
    if (axis_rx_tready !== 1'b0) begin fails++; $display("FAIL reset_tready: got %b want 0", axis_rx_tready); end
    if (data_fifo_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", data_fifo_valid); end
    if (pkt_count !== '0) begin fails++; $display("FAIL reset_pkt: got %0d want 0", pkt_count); end
    if (drop_count !== '0) begin fails++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    if (last_acc !== 1'b0) begin fails++; $display("FAIL reset_accept: beat accepted during reset"); end
    tvalid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_good_pkt();
    apply_reset();
    ren = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      send_beat(DATAW'(k), GOOD_HDR, '0, 1'(k == 3));
      compares += 3;
      if (data_fifo_valid !== 1'b1) begin fails++; $display("FAIL good_valid%0d: got %b want 1", k, data_fifo_valid); end
      if (data_fifo_rdata !== DATAW'(k)) begin fails++; $display("FAIL good_rdata%0d: got %0h want %0h", k, data_fifo_rdata, k); end
      if (data_fifo_rlast !== 1'(k == 3)) begin fails++; $display("FAIL good_rlast%0d: got %b want %b", k, data_fifo_rlast, k == 3); end
    end
    idle(3);
    compares += 4;
    if (pkt_count !== CNTW'(1)) begin fails++; $display("FAIL good_pkt_count: got %0d want 1", pkt_count); end
    if (drop_count !== CNTW'(0)) begin fails++; $display("FAIL good_drop_count: got %0d want 0", drop_count); end
    if (data_fifo_valid !== 1'b0) begin fails++; $display("FAIL good_drained: got %b want 0", data_fifo_valid); end
    if (got_out.size() != 3) begin fails++; $display("FAIL good_nbeats: got %0d want 3", got_out.size()); end
  endtask

  task automatic test_bad_header();
    apply_reset();
    ren = 1'b1;
    send_beat(rand_pl(), BAD_HDR, '0, 1'b0);
    send_beat(rand_pl(), BAD_HDR, '0, 1'b1);
    send_beat(DATAW'(8'hAB), GOOD_HDR, '0, 1'b1);
    compares += 3;
    if (data_fifo_valid !== 1'b1) begin fails++; $display("FAIL badhdr_valid: got %b want 1", data_fifo_valid); end
    if (data_fifo_rdata !== DATAW'(8'hAB)) begin fails++; $display("FAIL badhdr_rdata: got %0h want ab", data_fifo_rdata); end
    if (data_fifo_rlast !== 1'b1) begin fails++; $display("FAIL badhdr_rlast: got %b want 1", data_fifo_rlast); end
    idle(3);
    compares += 3;
    if (drop_count !== CNTW'(1)) begin fails++; $display("FAIL badhdr_drop: got %0d want 1", drop_count); end
    if (pkt_count !== CNTW'(1)) begin fails++; $display("FAIL badhdr_pkt: got %0d want 1", pkt_count); end
    if (got_out.size() != 1) begin fails++; $display("FAIL badhdr_nbeats: got %0d want 1", got_out.size()); end
  endtask

  task automatic test_bad_dest();
    apply_reset();
    ren = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_beat(rand_pl(), GOOD_HDR, DESTW'(5), 1'(k == 3));
      compares += 1;
      if (data_fifo_valid !== 1'b0) begin fails++; $display("FAIL baddest_valid%0d: got %b want 0", k, data_fifo_valid); end
      if (k < 3) begin
        compares += 1;
        if (axis_rx_tready !== 1'b1) begin fails++; $display("FAIL baddest_tready%0d: got %b want 1", k, axis_rx_tready); end
      end
    end
    idle(2);
    compares += 3;
    if (drop_count !== CNTW'(1)) begin fails++; $display("FAIL baddest_drop: got %0d want 1", drop_count); end
    if (pkt_count !== CNTW'(0)) begin fails++; $display("FAIL baddest_pkt: got %0d want 0", pkt_count); end
    if (data_fifo_valid !== 1'b0) begin fails++; $display("FAIL baddest_empty: got %b want 0", data_fifo_valid); end
  endtask

  task automatic test_full();
    int idx = 0;
    apply_reset();
    ren = 1'b0;
    for (int i = 0; i < N4; i++) pl4[i] = rand_pl();
    drive(pl4[0], GOOD_HDR, '0, 1'b0);
    tvalid = 1'b1;
    for (int c = 0; c < int'(DEPTH) + 20; c++) begin
      step();
      if (last_acc) begin
        idx++;
        if (idx < N4) drive(pl4[idx], GOOD_HDR, '0, 1'(idx == N4 - 1));
      end
    end
    compares += 4;
    if (idx != int'(DEPTH)) begin fails++; $display("FAIL full_accepted: got %0d want %0d", idx, DEPTH); end
    if (axis_rx_tready !== 1'b0) begin fails++; $display("FAIL full_tready: got %b want 0", axis_rx_tready); end
    if (axis_rx_tready !== (mfifo.size() < int'(DEPTH))) begin fails++; $display("FAIL full_tready_model: got %b occupancy %0d", axis_rx_tready, mfifo.size()); end
    if (data_fifo_rdata !== pl4[0]) begin fails++; $display("FAIL full_head: got %0h want %0h", data_fifo_rdata, pl4[0]); end
    // Single pop while full: no accept on that edge, exactly one on the next
    ren = 1'b1;
    step();
    ren = 1'b0;
    compares += 2;
    if (last_acc !== 1'b0) begin fails++; $display("FAIL full_pop_edge_accept: got %b want 0", last_acc); end
    if (axis_rx_tready !== 1'b1) begin fails++; $display("FAIL full_freed_tready: got %b want 1", axis_rx_tready); end
    if (last_acc) begin idx++; drive(pl4[idx], GOOD_HDR, '0, 1'(idx == N4 - 1)); end
    step();
    if (last_acc) begin idx++; drive(pl4[idx], GOOD_HDR, '0, 1'(idx == N4 - 1)); end
    step();
    if (last_acc) begin idx++; drive(pl4[idx], GOOD_HDR, '0, 1'(idx == N4 - 1)); end
    compares += 2;
    if (idx != int'(DEPTH) + 1) begin fails++; $display("FAIL full_one_more: got %0d want %0d", idx, DEPTH + 1); end
    if (axis_rx_tready !== 1'b0) begin fails++; $display("FAIL full_refull: got %b want 0", axis_rx_tready); end
    ren = 1'b1;
    for (int c = 0; c < 3000 && !(idx == N4 && got_out.size() == N4); c++) begin
      step();
      if (last_acc) begin
        idx++;
        if (idx < N4) drive(pl4[idx], GOOD_HDR, '0, 1'(idx == N4 - 1));
        else tvalid = 1'b0;
      end
    end
    compares += 2;
    if (got_out.size() != N4) begin fails++; $display("FAIL full_nbeats: got %0d want %0d", got_out.size(), N4); end
    if (pkt_count !== CNTW'(1)) begin fails++; $display("FAIL full_pkt: got %0d want 1", pkt_count); end
    for (int i = 0; i < N4 && i < got_out.size(); i++) begin
      compares++;
      if (got_out[i] !== {1'(i == N4 - 1), pl4[i]}) begin
        fails++; $display("FAIL full_beat%0d: got %0h want %0h", i, got_out[i], {1'(i == N4 - 1), pl4[i]});
      end
    end
  endtask

  task automatic test_midpkt_reset();
    logic [DATAW-1:0] a;
    logic [DATAW-1:0] b;
    apply_reset();
    ren = 1'b0;
    send_beat(rand_pl(), GOOD_HDR, '0, 1'b0);
    send_beat(rand_pl(), GOOD_HDR, '0, 1'b0);
    tvalid = 1'b0;
    rst = 1'b1;
    step();
    compares += 4;
    if (data_fifo_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", data_fifo_valid); end
    if (axis_rx_tready !== 1'b0) begin fails++; $display("FAIL midrst_tready: got %b want 0", axis_rx_tready); end
    if (pkt_count !== '0) begin fails++; $display("FAIL midrst_pkt: got %0d want 0", pkt_count); end
    if (drop_count !== '0) begin fails++; $display("FAIL midrst_drop: got %0d want 0", drop_count); end
    rst = 1'b0;
    a = rand_pl();
    b = rand_pl();
    send_beat(rand_pl(), BAD_HDR, '0, 1'b1);
    send_beat(a, GOOD_HDR, '0, 1'b0);
    send_beat(b, GOOD_HDR, '0, 1'b1);
    ren = 1'b1;
    idle(4);
    compares += 3;
    if (got_out.size() != 2) begin fails++; $display("FAIL midrst_nbeats: got %0d want 2", got_out.size()); end
    if (pkt_count !== CNTW'(1)) begin fails++; $display("FAIL midrst_pkt_after: got %0d want 1", pkt_count); end
    if (drop_count !== CNTW'(1)) begin fails++; $display("FAIL midrst_drop_after: got %0d want 1", drop_count); end
    if (got_out.size() == 2) begin
      compares += 2;
      if (got_out[0] !== {1'b0, a}) begin fails++; $display("FAIL midrst_beat0: got %0h want %0h", got_out[0], {1'b0, a}); end
      if (got_out[1] !== {1'b1, b}) begin fails++; $display("FAIL midrst_beat1: got %0h want %0h", got_out[1], {1'b1, b}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DATAW-1:0] p;
    apply_reset();
    ren = 1'b1;
    for (int k = 0; k < 20; k++) begin
      p = rand_pl();
      send_beat(p, GOOD_HDR, '0, 1'b1);
      compares += 3;
      if (data_fifo_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid%0d: got %b want 1", k, data_fifo_valid); end
      if (data_fifo_rdata !== p) begin fails++; $display("FAIL b2b_rdata%0d: got %0h want %0h", k, data_fifo_rdata, p); end
      if (pkt_count !== CNTW'((k + 1 < SAT) ? k + 1 : SAT)) begin
        fails++; $display("FAIL b2b_pkt%0d: got %0d want %0d", k, pkt_count, (k + 1 < SAT) ? k + 1 : SAT);
      end
    end
    idle(2);
    compares += 2;
    if (pkt_count !== CNTW'(SAT)) begin fails++; $display("FAIL b2b_sat: got %0d want %0d", pkt_count, SAT); end
    if (drop_count !== CNTW'(0)) begin fails++; $display("FAIL b2b_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_random();
    int len;
    int n;
    logic [USERW-1:0] hdr;
    logic [DESTW-1:0] dest;
    apply_reset();
    rand_ren = 1'b1;
    for (int p = 0; p < 24; p++) begin
      len  = $urandom_range(1, 5);
      hdr  = ($urandom_range(0, 3) != 0) ? GOOD_HDR : USERW'($urandom_range(0, 2047));
      dest = ($urandom_range(0, 3) != 0) ? '0 : DESTW'($urandom_range(1, 127));
      for (int b = 0; b < len; b++) begin
        tvalid = 1'b0;
        repeat ($urandom_range(0, 1)) step();
        send_beat(rand_pl(), hdr, dest, 1'(b == len - 1));
      end
    end
    rand_ren = 1'b0;
    ren = 1'b1;
    tvalid = 1'b0;
    n = 0;
    while ((mfifo.size() > 0 || data_fifo_valid) && n < 2000) begin step(); n++; end
    idle(2);
    compares += 3;
    if (got_out.size() != exp_out.size()) begin fails++; $display("FAIL rand_nbeats: got %0d want %0d", got_out.size(), exp_out.size()); end
    if (pkt_count !== CNTW'(m_pkt)) begin fails++; $display("FAIL rand_pkt: got %0d want %0d", pkt_count, m_pkt); end
    if (drop_count !== CNTW'(m_drop)) begin fails++; $display("FAIL rand_drop: got %0d want %0d", drop_count, m_drop); end
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++) begin
      compares++;
      if (got_out[i] !== exp_out[i]) begin fails++; $display("FAIL rand_beat%0d: got %0h want %0h", i, got_out[i], exp_out[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; tvalid = 1'b0; ren = 1'b0; rand_ren = 1'b0;
    tdata = '0; tdest = '0; tlast = 1'b0;
    tstrb = '1; tkeep = '1; tid = '0; tuser = '0;
    m_in_pkt = 1'b0; m_good = 1'b0; m_pkt = 0; m_drop = 0; last_acc = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_good_pkt();
    test_bad_header();
    test_bad_dest();
    test_full();
    test_midpkt_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
